// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types and helpers for the bit-serial MAC sequencer.
//   bsmac_state_t  - sequencer FSM states (IDLE, STREAM, DRAIN, HOLD)
//   bsmac_acc_bits - signed accumulator width for a given ADC width and
//                    maximum input precision
package qracc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      HOLD   = 2'd3
   } bsmac_state_t;

   // One extra doubling of the ADC range per issued plane.
   function automatic int bsmac_acc_bits(input int adc_bits, input int max_in_bits);
      return adc_bits + max_in_bits;
   endfunction

endpackage

// File: rtl/bsmac_plane_drv.sv
// bsmac_plane_drv: combinational bit-plane selector with sign routing.
// Picks bit <plane> of every input lane and routes it to the positive or
// negative wordline drive. Both drives are zero when en is low.
// Ports:
//   data  in  IN_ELEMS*MAX_IN_BITS  latched activations, lane i at [i*MAX_IN_BITS +: MAX_IN_BITS]
//   plane in  PLANE_W               bit-plane index
//   en    in  1                     plane issue strobe
//   neg   in  1                     current plane carries negative weight
//   x_p   out IN_ELEMS              positive wordline drive
//   x_n   out IN_ELEMS              negative wordline drive
module bsmac_plane_drv
   import qracc_pkg::*;
#(
   parameter int MAX_IN_BITS = 8,
   parameter int IN_ELEMS    = 128,
   parameter int PLANE_W     = 3
) (
   input  logic [IN_ELEMS*MAX_IN_BITS-1:0] data,
   input  logic [PLANE_W-1:0]              plane,
   input  logic                            en,
   input  logic                            neg,
   output logic [IN_ELEMS-1:0]             x_p,
   output logic [IN_ELEMS-1:0]             x_n
);

   // Lanes are zero-padded to a power of two so the plane index has an
   // exact-width select.
   localparam int LANE_W = 1 << PLANE_W;

   logic [IN_ELEMS-1:0] plane_bits;

   for (genvar gi = 0; gi < IN_ELEMS; gi++) begin : g_lane
      logic [LANE_W-1:0] lane;
      assign lane           = LANE_W'(data[gi*MAX_IN_BITS +: MAX_IN_BITS]);
      assign plane_bits[gi] = lane[plane];
   end

   assign x_p = (en && !neg) ? plane_bits : '0;
   assign x_n = (en &&  neg) ? plane_bits : '0;

endmodule

// File: rtl/bitserial_mac_seq.sv
// bitserial_mac_seq: bit-serial input sequencer and shift-accumulator for
// the analog MAC array. Accepts one activation vector per handshake, issues
// it MSB-plane first (one plane per cycle), accumulates the signed per-column
// ADC results, then rounds/rescales and presents them on a valid/ready port.
// Build option: define BSMAC_SAT_EN to saturate results to OUT_BITS; without
// it results wrap (low OUT_BITS bits kept).
// Ports:
//   clk, nrst (synchronous, active-low)
//   cfg_in_bits_i / cfg_signed_i / cfg_out_shift_i  per-operation config, sampled on accept
//   in_valid_i / in_ready_o / in_data_i             activation input handshake
//   mac_en_o / x_p_o / x_n_o                        array evaluate strobe and wordline drives
//   adc_i                                           signed per-column ADC results, ADC_LAT after mac_en_o
//   out_valid_o / out_ready_i / out_data_o          result output handshake
module bitserial_mac_seq
   import qracc_pkg::*;
#(
   parameter int MAX_IN_BITS = 8,
   parameter int IN_ELEMS    = 128,
   parameter int OUT_ELEMS   = 32,
   parameter int ADC_BITS    = 4,
   parameter int ADC_LAT     = 1,
   parameter int OUT_BITS    = 8,
   localparam int ACC_BITS   = bsmac_acc_bits(ADC_BITS, MAX_IN_BITS),
   localparam int CNT_W      = $clog2(MAX_IN_BITS + 1),
   localparam int SH_W       = $clog2(ACC_BITS)
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic [CNT_W-1:0]                  cfg_in_bits_i,
   input  logic                              cfg_signed_i,
   input  logic [SH_W-1:0]                   cfg_out_shift_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [IN_ELEMS*MAX_IN_BITS-1:0]   in_data_i,
   output logic                              mac_en_o,
   output logic [IN_ELEMS-1:0]               x_p_o,
   output logic [IN_ELEMS-1:0]               x_n_o,
   input  logic [OUT_ELEMS*ADC_BITS-1:0]     adc_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [OUT_ELEMS*OUT_BITS-1:0]     out_data_o
);

   localparam int PLANE_W = (MAX_IN_BITS > 1) ? $clog2(MAX_IN_BITS) : 1;
   // One guard bit so adding the rounding constant never overflows.
   localparam int RW      = ACC_BITS + 1;

   bsmac_state_t state_reg, state_next;

   logic [IN_ELEMS*MAX_IN_BITS-1:0] data_reg;
   logic [CNT_W-1:0]                n_reg;
   logic                            signed_reg;
   logic [SH_W-1:0]                 shift_reg;
   logic [CNT_W-1:0]                plane_reg;
   logic [CNT_W-1:0]                res_cnt_reg;   // ADC results still expected
   logic [ADC_LAT-1:0]              en_dly_reg;

   logic [CNT_W-1:0] n_clamp;
   logic             accept;
   logic             neg_plane;
   logic             adc_vld;
   logic             res_first;
   logic             res_last;
   logic [RW-1:0]    half_u;

   // ---------------------------------------------------------------
   // Configuration clamp: 0 planes means 1, more than MAX_IN_BITS saturates.
   // ---------------------------------------------------------------
   always_comb begin
      n_clamp = cfg_in_bits_i;
      if (cfg_in_bits_i == '0)
         n_clamp = CNT_W'(1);
      else if (cfg_in_bits_i > CNT_W'(MAX_IN_BITS))
         n_clamp = CNT_W'(MAX_IN_BITS);
   end

   assign accept    = in_valid_i && in_ready_o;
   assign adc_vld   = en_dly_reg[ADC_LAT-1] && (res_cnt_reg != '0);
   assign res_first = (res_cnt_reg == n_reg);
   assign res_last  = (res_cnt_reg == CNT_W'(1));

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nrst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid_i) state_next = STREAM;
         STREAM:  if (plane_reg == '0) state_next = DRAIN;
         // The last result always lands after STREAM since ADC_LAT >= 1.
         DRAIN:   if (adc_vld && res_last) state_next = HOLD;
         HOLD:    if (out_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready_o  = 1'b0;
      mac_en_o    = 1'b0;
      out_valid_o = 1'b0;
      neg_plane   = 1'b0;
      case (state_reg)
         IDLE:    in_ready_o = 1'b1;
         STREAM: begin
            mac_en_o  = 1'b1;
            // Only the MSB plane of a two's-complement input is negative.
            neg_plane = signed_reg && (plane_reg == n_reg - CNT_W'(1));
         end
         HOLD:    out_valid_o = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Operand latch, plane/result counters and ADC-latency delay line
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nrst) begin
         data_reg    <= '0;
         n_reg       <= '0;
         signed_reg  <= 1'b0;
         shift_reg   <= '0;
         plane_reg   <= '0;
         res_cnt_reg <= '0;
         en_dly_reg  <= '0;   // drops any in-flight ADC results
      end else begin
         en_dly_reg <= ADC_LAT'({en_dly_reg, mac_en_o});
         if (accept) begin
            data_reg    <= in_data_i;
            n_reg       <= n_clamp;
            signed_reg  <= cfg_signed_i;
            shift_reg   <= cfg_out_shift_i;
            plane_reg   <= n_clamp - CNT_W'(1);
            res_cnt_reg <= n_clamp;
         end else if (state_reg == STREAM && plane_reg != '0) begin
            plane_reg <= plane_reg - CNT_W'(1);
         end
         if (adc_vld)
            res_cnt_reg <= res_cnt_reg - CNT_W'(1);
      end
   end

   bsmac_plane_drv #(
      .MAX_IN_BITS (MAX_IN_BITS),
      .IN_ELEMS    (IN_ELEMS),
      .PLANE_W     (PLANE_W)
   ) u_plane_drv (
      .data  (data_reg),
      .plane (plane_reg[PLANE_W-1:0]),
      .en    (mac_en_o),
      .neg   (neg_plane),
      .x_p   (x_p_o),
      .x_n   (x_n_o)
   );

   // Round-half-up constant: 1 << (shift-1), or 0 when shift is 0.
   assign half_u = ({{(RW-1){1'b0}}, 1'b1} << shift_reg) >> 1;

`ifdef BSMAC_SAT_EN
   localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] SAT_MIN = RW'(-(64'sd1 <<< (OUT_BITS - 1)));
`endif

   // ---------------------------------------------------------------
   // Per-column accumulator and output stage
   // ---------------------------------------------------------------
   for (genvar gi = 0; gi < OUT_ELEMS; gi++) begin : g_col
      logic signed [ACC_BITS-1:0] adc_ext;
      logic signed [ACC_BITS-1:0] acc_reg;
      logic signed [ACC_BITS-1:0] acc_next;
      logic signed [RW-1:0]       sum;
      logic signed [RW-1:0]       rnd;
      logic [OUT_BITS-1:0]        res;
      logic [OUT_BITS-1:0]        out_reg;

      assign adc_ext  = {{(ACC_BITS-ADC_BITS){adc_i[gi*ADC_BITS+ADC_BITS-1]}},
                         adc_i[gi*ADC_BITS +: ADC_BITS]};
      // MSB plane arrives first, so each later plane doubles the running sum.
      assign acc_next = res_first ? adc_ext : ((acc_reg <<< 1) + adc_ext);
      assign sum      = {acc_next[ACC_BITS-1], acc_next} + half_u;
      assign rnd      = sum >>> shift_reg;

`ifdef BSMAC_SAT_EN
      always_comb begin
         res = rnd[OUT_BITS-1:0];
         if (rnd > SAT_MAX)
            res = SAT_MAX[OUT_BITS-1:0];
         else if (rnd < SAT_MIN)
            res = SAT_MIN[OUT_BITS-1:0];
      end
`else
      assign res = rnd[OUT_BITS-1:0];
`endif

      // The result is captured together with the last ADC sample so it is
      // already registered when HOLD is entered.
      always_ff @(posedge clk) begin
         if (!nrst) begin
            acc_reg <= '0;
            out_reg <= '0;
         end else if (adc_vld) begin
            acc_reg <= acc_next;
            if (res_last)
               out_reg <= res;
         end
      end

      assign out_data_o[gi*OUT_BITS +: OUT_BITS] = out_reg;
   end

endmodule
